gs_div_ctrl: RTL and testbench

GS_DIV_CTRL -- requirements
Module: gs_div_ctrl

---
 rtl/gs_div_ctrl.sv | 158 +++++++++++++++
 tb/tb_gs_div_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gs_div_ctrl.sv
// Goldschmidt divider control FSM: sequences IA then K refinement passes.
// Optional GS_IA_ROM_EN: capture IA from an internal seed table instead of ia_in.
module gs_div_ctrl #(
  parameter int ITERATIONS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        in_ready,
  input  logic [15:0] n_in,
  input  logic [15:0] d_in,
  input  logic [15:0] ia_in,
  output logic [15:0] N,
  output logic [15:0] D,
  output logic [15:0] IA,
  output logic        load_regN,
  output logic        load_regD,
  output logic [1:0]  sel_ND_mux,
  output logic        sel_K_mux,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IA_D,
    S_IA_N,
    S_K_D,
    S_K_N,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(ITERATIONS - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [15:0] r_n;
  logic [15:0] r_d;
  logic [15:0] r_ia;
  logic        r_err;
  logic        w_accept;
  logic [15:0] w_ia_src;

  assign w_accept = start & in_ready;

`ifdef GS_IA_ROM_EN
  // round(32768 / (1 + (i + 0.5) / 8)), i = d_in[14:12]
  always_comb begin
    w_ia_src = 16'h0000;
    unique case (d_in[14:12])
      3'd0: w_ia_src = 16'h7878;
      3'd1: w_ia_src = 16'h6BCA;
      3'd2: w_ia_src = 16'h6186;
      3'd3: w_ia_src = 16'h590B;
      3'd4: w_ia_src = 16'h51EC;
      3'd5: w_ia_src = 16'h4BDA;
      3'd6: w_ia_src = 16'h469F;
      3'd7: w_ia_src = 16'h4211;
      default: w_ia_src = 16'h0000;
    endcase
  end
`else
  assign w_ia_src = ia_in;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = d_in[15] ? S_IA_D : S_DONE;
        end
      end
      S_IA_D: w_next = S_IA_N;
      S_IA_N: w_next = S_K_D;
      S_K_D:  w_next = S_K_N;
      S_K_N:  w_next = (r_cnt == LAST) ? S_DONE : S_K_D;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    load_regN  = 1'b0;
    load_regD  = 1'b0;
    sel_ND_mux = 2'b00;
    sel_K_mux  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    in_ready   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy     = 1'b0;
        in_ready = ~reset;
      end
      S_IA_D: begin
        load_regD = 1'b1;
        sel_K_mux = 1'b1;
      end
      S_IA_N: begin
        load_regN  = 1'b1;
        sel_ND_mux = 2'b01;
        sel_K_mux  = 1'b1;
      end
      S_K_D: begin
        load_regD  = 1'b1;
        sel_ND_mux = 2'b10;
      end
      S_K_N: begin
        load_regN  = 1'b1;
        sel_ND_mux = 2'b11;
      end
      S_DONE: done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 4'd0;
    end else if (r_state == S_IA_N) begin
      r_cnt <= 4'd0;
    end else if (r_state == S_K_N && r_cnt != LAST) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // Operands are frozen from accept until the next accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_n   <= 16'h0000;
      r_d   <= 16'h0000;
      r_ia  <= 16'h0000;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_n   <= n_in;
      r_d   <= d_in;
      r_ia  <= w_ia_src;
      r_err <= ~d_in[15];
    end
  end

  assign N   = r_n;
  assign D   = r_d;
  assign IA  = r_ia;
  assign err = r_err;

endmodule

// File: tb/tb_gs_div_ctrl.sv
// Scoreboard bench for gs_div_ctrl: per-cycle expected control words
// are queued at accept and popped by monitors on every busy cycle.
module tb_gs_div_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic        start1;
  logic [15:0] n_in;
  logic [15:0] d_in;
  logic [15:0] ia_in;

  logic        in_ready, load_regN, load_regD, sel_K_mux, busy, done, err;
  logic [1:0]  sel_ND_mux;
  logic [15:0] N, D, IA;

  logic        in_ready1, load_regN1, load_regD1, sel_K_mux1, busy1, done1, err1;
  logic [1:0]  sel_ND_mux1;
  logic [15:0] N1, D1, IA1;

  gs_div_ctrl #(.ITERATIONS(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .in_ready(in_ready),
    .n_in(n_in), .d_in(d_in), .ia_in(ia_in),
    .N(N), .D(D), .IA(IA),
    .load_regN(load_regN), .load_regD(load_regD),
    .sel_ND_mux(sel_ND_mux), .sel_K_mux(sel_K_mux),
    .busy(busy), .done(done), .err(err)
  );

  gs_div_ctrl #(.ITERATIONS(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .in_ready(in_ready1),
    .n_in(n_in), .d_in(d_in), .ia_in(ia_in),
    .N(N1), .D(D1), .IA(IA1),
    .load_regN(load_regN1), .load_regD(load_regD1),
    .sel_ND_mux(sel_ND_mux1), .sel_K_mux(sel_K_mux1),
    .busy(busy1), .done(done1), .err(err1)
  );

  typedef struct packed {
    logic        ldn;
    logic        ldd;
    logic [1:0]  sel;
    logic        selk;
    logic        dn;
    logic        er;
    logic [15:0] n;
    logic [15:0] d;
    logic [15:0] ia;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic ldn, input logic ldd,
                              input logic [1:0] sel, input logic selk,
                              input logic dn, input logic er,
                              input logic [15:0] n, input logic [15:0] d,
                              input logic [15:0] ia);
    return exp_t'({ldn, ldd, sel, selk, dn, er, n, d, ia});
  endfunction

  function automatic logic [15:0] exp_ia(input logic [15:0] d,
                                         input logic [15:0] ia);
`ifdef GS_IA_ROM_EN
    logic [15:0] tbl [8];
    tbl = '{16'h7878, 16'h6BCA, 16'h6186, 16'h590B,
            16'h51EC, 16'h4BDA, 16'h469F, 16'h4211};
    return tbl[d[14:12]];
`else
    return ia;
`endif
  endfunction

  task automatic push_seq(input int which, input int it,
                          input logic [15:0] n, input logic [15:0] d,
                          input logic [15:0] ia);
    exp_t s[$];
    logic [15:0] a;
    a = exp_ia(d, ia);
    if (!d[15]) begin
      s.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, n, d, a));
    end else begin
      s.push_back(mk(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, n, d, a));
      s.push_back(mk(1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, n, d, a));
      for (int k = 0; k < it; k++) begin
        s.push_back(mk(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, n, d, a));
        s.push_back(mk(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, n, d, a));
      end
      s.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, n, d, a));
    end
    foreach (s[k]) begin
      if (which == 0) q0.push_back(s[k]);
      else q1.push_back(s[k]);
    end
  endtask

  // Returns 1 ns after the accept edge, i.e. early in cycle 1.
  task automatic go(input bit s0, input bit s1, input logic [15:0] n,
                    input logic [15:0] d, input logic [15:0] ia);
    @(negedge clk);
    n_in  = n;
    d_in  = d;
    ia_in = ia;
    if (s0) begin start = 1'b1; push_seq(0, 4, n, d, ia); end
    if (s1) begin start1 = 1'b1; push_seq(1, 1, n, d, ia); end
    @(posedge clk);
    #1;
    start  = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL timeout: pending %0d/%0d expected 0/0",
               q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && busy) begin
      if (q0.size() == 0) begin
        chk("dut4_unexpected_busy", 64'(busy), 64'd0);
      end else begin
        e0 = q0.pop_front();
        chk("dut4_cycle",
            64'({load_regN, load_regD, sel_ND_mux, sel_K_mux,
                 done, err, N, D, IA}), 64'(e0));
        chk("dut4_onehot_loads", 64'(load_regN & load_regD), 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && busy1) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_busy", 64'(busy1), 64'd0);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_cycle",
            64'({load_regN1, load_regD1, sel_ND_mux1, sel_K_mux1,
                 done1, err1, N1, D1, IA1}), 64'(e1));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    start1 = 1'b0;
    n_in   = 16'h0;
    d_in   = 16'h0;
    ia_in  = 16'h0;
    #1;
    chk("in_reset_ready", 64'(in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_ready", 64'({in_ready, busy, done, err}), 64'b1000);
    chk("rst_ctl", 64'({load_regN, load_regD, sel_ND_mux, sel_K_mux}),
        64'd0);
    chk("rst_regs", 64'({N, D, IA}), 64'd0);
    chk("rst_ready1", 64'({in_ready1, busy1}), 64'b10);

    // Basic run on both instances (4 passes / 1 pass).
    go(1'b1, 1'b1, 16'hC000, 16'hA000, 16'h6000);
    wait_done();

    // Start mid-operation and during DONE must be ignored.
    go(1'b1, 1'b0, 16'h9000, 16'hC000, 16'h5555);
    repeat (4) @(posedge clk);
    #1;
    chk("busy_blocks_ready", 64'(in_ready), 64'd0);
    n_in = 16'h1234; d_in = 16'hF000; ia_in = 16'h4444;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("in_done_state", 64'(done), 64'd1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("done_start_ignored", 64'({busy, N}), 64'({1'b0, 16'h9000}));
    wait_done();

    // Reset during K_D of the second pass.
    go(1'b1, 1'b0, 16'hB000, 16'hE000, 16'h4900);
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    q0.delete();
    #1;
    chk("midrst_ctl", 64'({in_ready, busy, done, err, load_regN,
                           load_regD, sel_ND_mux, sel_K_mux}), 64'd0);
    chk("midrst_regs", 64'({N, D, IA}), 64'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_release_ready", 64'(in_ready), 64'd1);
    go(1'b1, 1'b0, 16'hD000, 16'h8800, 16'h7100);
    wait_done();

    // Unnormalized divisor on both instances.
    go(1'b1, 1'b1, 16'h9000, 16'h4000, 16'h7000);
    wait_done();
    chk("err_held", 64'({err, in_ready, done}), 64'b110);
    chk("err_held1", 64'(err1), 64'd1);

    // Next accept clears err; also checks the IA source.
    go(1'b1, 1'b0, 16'h8000, 16'hA000, 16'hFFFF);
`ifdef GS_IA_ROM_EN
    chk("ia_capture", 64'(IA), 64'h6186);
`else
    chk("ia_capture", 64'(IA), 64'hFFFF);
`endif
    chk("err_cleared", 64'(err), 64'd0);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
